// File: rtl/lp_piped_sum_n.sv
// Pipelined N-operand signed adder with saturate/wrap result, per-stage valid bits,
// a downstream ready chain that collapses bubbles, flush, and launch/arrive tag tracking.
module lp_piped_sum_n #(
  parameter int WIDTH    = 16,
  parameter int NUM_IN   = 4,
  parameter int STAGES   = 3,
  parameter int ID_WIDTH = 8,
  parameter bit SAT_MODE = 1'b1,
  parameter bit NO_PM    = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_IN*WIDTH-1:0]         ops,
  input  logic                            launch,
  input  logic [ID_WIDTH-1:0]             launch_id,
  input  logic                            flush,
  input  logic                            accept_n,
  output logic [WIDTH-1:0]                z,
  output logic [1:0]                      status,
  output logic                            arrive,
  output logic [ID_WIDTH-1:0]             arrive_id,
  output logic                            push_out_n,
  output logic                            pipe_full,
  output logic                            pipe_ovf,
  output logic [$clog2(STAGES+1)-1:0]     pipe_census
);

  localparam int SW = WIDTH + $clog2(NUM_IN);
  localparam int CW = $clog2(STAGES+1);

  logic signed [SW-1:0] ops_ext [NUM_IN];
  logic signed [SW-1:0] full_sum;
  logic [SW-WIDTH:0]    top_bits;
  logic                 sum_ovf;
  logic [WIDTH-1:0]     sat_val;
  logic [WIDTH-1:0]     res_z;
  logic [1:0]           res_st;

  logic [STAGES-1:0]    v_reg;
  logic [WIDTH-1:0]     z_reg  [STAGES];
  logic [1:0]           st_reg [STAGES];
  logic [ID_WIDTH-1:0]  id_reg [STAGES];
  logic                 pipe_ovf_reg;

  logic [STAGES-1:0]    ready;
  logic [STAGES-1:0]    in_v;
  logic [WIDTH-1:0]     in_z   [STAGES];
  logic [1:0]           in_st  [STAGES];
  logic [ID_WIDTH-1:0]  in_id  [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_ext
      assign ops_ext[gi] = {{(SW-WIDTH){ops[gi*WIDTH+WIDTH-1]}}, ops[gi*WIDTH +: WIDTH]};
    end
  endgenerate

  // The full sum and its clamp are resolved before stage 1; later stages only carry the result.
  always_comb begin
    full_sum = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      full_sum = full_sum + ops_ext[i];
    end
  end

  // In range exactly when every bit above the result sign bit matches it.
  assign top_bits = full_sum[SW-1:WIDTH-1];
  assign sum_ovf  = ~((&top_bits) | ~(|top_bits));
  assign sat_val  = full_sum[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign res_z    = (SAT_MODE && sum_ovf) ? sat_val : full_sum[WIDTH-1:0];
  assign res_st   = {(res_z == '0), sum_ovf};

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_src
      if (gi == 0) begin : g_first
        assign in_v[gi]  = launch;
        assign in_z[gi]  = res_z;
        assign in_st[gi] = res_st;
        assign in_id[gi] = launch_id;
      end else begin : g_next
        assign in_v[gi]  = v_reg[gi-1];
        assign in_z[gi]  = z_reg[gi-1];
        assign in_st[gi] = st_reg[gi-1];
        assign in_id[gi] = id_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    logic r;
    ready = '0;
    r = NO_PM | ~accept_n;
    for (int k = STAGES-1; k >= 0; k--) begin
      r = NO_PM | ~v_reg[k] | r;
      ready[k] = r;
    end
  end

  // Data registers only load on a valid transfer so bubbles leave them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg        <= '0;
      pipe_ovf_reg <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        z_reg[k]  <= '0;
        st_reg[k] <= '0;
        id_reg[k] <= '0;
      end
    end else begin
      pipe_ovf_reg <= launch & ~ready[0] & ~flush;
      for (int k = 0; k < STAGES; k++) begin
        if (flush) begin
          v_reg[k] <= 1'b0;
        end else if (ready[k]) begin
          v_reg[k] <= in_v[k];
        end
        if (ready[k] && in_v[k]) begin
          z_reg[k]  <= in_z[k];
          st_reg[k] <= in_st[k];
          id_reg[k] <= in_id[k];
        end
      end
    end
  end

  always_comb begin
    pipe_census = '0;
    for (int k = 0; k < STAGES; k++) begin
      pipe_census = pipe_census + CW'(v_reg[k]);
    end
  end

  assign z          = z_reg[STAGES-1];
  assign status     = st_reg[STAGES-1];
  assign arrive_id  = id_reg[STAGES-1];
  assign arrive     = v_reg[STAGES-1];
  assign push_out_n = ~(arrive & (NO_PM | ~accept_n));
  assign pipe_full  = ~ready[0];
  assign pipe_ovf   = pipe_ovf_reg;

endmodule

// File: tb/tb_lp_piped_sum_n.sv
// Bench for lp_piped_sum_n: a managed saturating instance and an unmanaged wrapping
// instance share stimulus; results are scoreboarded, corner sequences checked by hand.
module tb_lp_piped_sum_n;

  logic        clk = 1'b0;
  logic        rst, launch, flush, accept_n;
  logic [31:0] ops;
  logic [7:0]  launch_id;

  logic [7:0] z_s, aid_s, z_w, aid_w;
  logic [1:0] st_s, st_w, cen_s, cen_w;
  logic       arr_s, pon_s, full_s, ovf_s;
  logic       arr_w, pon_w, full_w, ovf_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit sb_on = 1'b0;
  bit hs, hw;

  typedef struct {
    logic [31:0] ops;
    logic [7:0]  id;
    logic [7:0]  zs;
    logic [1:0]  ss;
    logic [7:0]  zw;
    logic [1:0]  sw;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] id;
    logic [7:0] z;
    logic [1:0] st;
  } exp_t;

  vec_t tbl [13];
  exp_t q_s[$];
  exp_t q_w[$];

  lp_piped_sum_n #(.WIDTH(8), .NUM_IN(4), .STAGES(3), .ID_WIDTH(8),
                   .SAT_MODE(1'b1), .NO_PM(1'b0)) dut_s (
    .clk(clk), .rst(rst), .ops(ops), .launch(launch), .launch_id(launch_id),
    .flush(flush), .accept_n(accept_n), .z(z_s), .status(st_s), .arrive(arr_s),
    .arrive_id(aid_s), .push_out_n(pon_s), .pipe_full(full_s), .pipe_ovf(ovf_s),
    .pipe_census(cen_s)
  );

  lp_piped_sum_n #(.WIDTH(8), .NUM_IN(4), .STAGES(3), .ID_WIDTH(8),
                   .SAT_MODE(1'b0), .NO_PM(1'b1)) dut_w (
    .clk(clk), .rst(rst), .ops(ops), .launch(launch), .launch_id(launch_id),
    .flush(flush), .accept_n(accept_n), .z(z_w), .status(st_w), .arrive(arr_w),
    .arrive_id(aid_w), .push_out_n(pon_w), .pipe_full(full_w), .pipe_ovf(ovf_w),
    .pipe_census(cen_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic drive(input logic l, input logic [7:0] id, input int val);
    launch = l;
    launch_id = id;
    ops = pk(val, 0, 0, 0);
  endtask

  function automatic void model(input logic [31:0] o, input bit sat,
                                output logic [7:0] zz, output logic [1:0] ss);
    int s;
    bit ov;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'($signed(o[i*8 +: 8]));
    ov = (s > 127) || (s < -128);
    if (sat && s > 127) zz = 8'h7F;
    else if (sat && s < -128) zz = 8'h80;
    else zz = s[7:0];
    ss = {(zz == 8'h00), ov};
  endfunction

  task automatic chk_rst(input string p, input logic [7:0] zz, input logic [1:0] ss,
                         input logic aa, input logic [7:0] ii, input logic pn,
                         input logic pf, input logic po, input logic [1:0] cc);
    chk({p, " rst z"}, zz, 0);
    chk({p, " rst status"}, ss, 0);
    chk({p, " rst arrive"}, aa, 0);
    chk({p, " rst arrive_id"}, ii, 0);
    chk({p, " rst push_out_n"}, pn, 1);
    chk({p, " rst pipe_full"}, pf, 0);
    chk({p, " rst pipe_ovf"}, po, 0);
    chk({p, " rst census"}, cc, 0);
  endtask

  task automatic push_exp(input logic [31:0] o, input logic [7:0] id,
                          input logic [7:0] zs, input logic [1:0] ss,
                          input logic [7:0] zw, input logic [1:0] sw);
    ops = o;
    launch = 1'b1;
    launch_id = id;
    q_s.push_back('{cyc + 3, id, zs, ss});
    q_w.push_back('{cyc + 3, id, zw, sw});
  endtask

  // Scoreboard: each expected result is due exactly three cycles after its launch.
  always @(negedge clk) begin
    if (sb_on) begin
      hs = (q_s.size() > 0) && (q_s[0].due == cyc);
      hw = (q_w.size() > 0) && (q_w[0].due == cyc);
      chk("sb sat arrive", arr_s, hs);
      chk("sb sat push_out_n", pon_s, !hs);
      if (hs) begin
        chk("sb sat z", z_s, q_s[0].z);
        chk("sb sat status", st_s, q_s[0].st);
        chk("sb sat arrive_id", aid_s, q_s[0].id);
        $display("txn sat  id=%02h z=%02h status=%b cycle=%0d", aid_s, z_s, st_s, cyc);
        void'(q_s.pop_front());
      end
      chk("sb wrap arrive", arr_w, hw);
      chk("sb wrap push_out_n", pon_w, !hw);
      if (hw) begin
        chk("sb wrap z", z_w, q_w[0].z);
        chk("sb wrap status", st_w, q_w[0].st);
        chk("sb wrap arrive_id", aid_w, q_w[0].id);
        $display("txn wrap id=%02h z=%02h status=%b cycle=%0d", aid_w, z_w, st_w, cyc);
        void'(q_w.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  mzs, mzw;
    logic [1:0]  mss, msw;

    tbl[0]  = '{pk(1, 2, 3, 4),           8'h5A, 8'h0A, 2'b00, 8'h0A, 2'b00};
    tbl[1]  = '{pk(100, 100, 100, 0),     8'h01, 8'h7F, 2'b01, 8'h2C, 2'b01};
    tbl[2]  = '{pk(-100, -100, -100, 0),  8'h02, 8'h80, 2'b01, 8'hD4, 2'b01};
    tbl[3]  = '{pk(5, -5, 0, 0),          8'h03, 8'h00, 2'b10, 8'h00, 2'b10};
    tbl[4]  = '{pk(127, 127, 127, 127),   8'h04, 8'h7F, 2'b01, 8'hFC, 2'b01};
    tbl[5]  = '{pk(-128, -128, -128, -128), 8'h05, 8'h80, 2'b01, 8'h00, 2'b11};
    tbl[6]  = '{pk(127, 1, 0, 0),         8'h06, 8'h7F, 2'b01, 8'h80, 2'b01};
    tbl[7]  = '{pk(-128, -1, 1, 0),       8'h07, 8'h80, 2'b00, 8'h80, 2'b00};
    tbl[8]  = '{pk(127, 127, 2, 0),       8'h08, 8'h7F, 2'b01, 8'h00, 2'b11};
    tbl[9]  = '{pk(-64, -64, -1, 0),      8'h09, 8'h80, 2'b01, 8'h7F, 2'b01};
    tbl[10] = '{pk(100, -50, -25, -25),   8'h0A, 8'h00, 2'b10, 8'h00, 2'b10};
    tbl[11] = '{pk(64, 63, 0, 0),         8'h0B, 8'h7F, 2'b00, 8'h7F, 2'b00};
    tbl[12] = '{pk(-1, -1, -1, -1),       8'h0C, 8'hFC, 2'b00, 8'hFC, 2'b00};

    // Reset held two cycles with launch asserted.
    rst = 1'b1; launch = 1'b1; ops = pk(1, 2, 3, 4); launch_id = 8'hEE;
    flush = 1'b0; accept_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; launch = 1'b0;
    @(negedge clk);
    chk_rst("sat", z_s, st_s, arr_s, aid_s, pon_s, full_s, ovf_s, cen_s);
    chk_rst("wrap", z_w, st_w, arr_w, aid_w, pon_w, full_w, ovf_w, cen_w);

    // Back-to-back table vectors then random vectors, all accepted.
    tick();
    sb_on = 1'b1;
    for (int i = 0; i < 13; i++) begin
      push_exp(tbl[i].ops, tbl[i].id, tbl[i].zs, tbl[i].ss, tbl[i].zw, tbl[i].sw);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      r = $urandom;
      model(r, 1'b1, mzs, mss);
      model(r, 1'b0, mzw, msw);
      push_exp(r, 8'h60 + 8'(k), mzs, mss, mzw, msw);
      tick();
    end
    launch = 1'b0;
    for (int k = 0; k < 8 && (q_s.size() != 0 || q_w.size() != 0); k++) tick();
    chk("sb drain", q_s.size() + q_w.size(), 0);
    sb_on = 1'b0;

    // Back-pressure: three fill the pipe, the fourth is dropped.
    accept_n = 1'b1;
    drive(1'b1, 8'h10, 16); tick();
    drive(1'b1, 8'h11, 17); tick();
    drive(1'b1, 8'h12, 18); tick();
    drive(1'b1, 8'h13, 19);
    @(negedge clk);
    chk("bp pipe_full", full_s, 1);
    chk("bp census", cen_s, 3);
    chk("nopm pipe_full", full_w, 0);
    chk("nopm arrive_id c3", aid_w, 8'h10);
    chk("nopm push ignores accept_n", pon_w, 0);
    tick(); launch = 1'b0;
    @(negedge clk);
    chk("bp ovf pulse", ovf_s, 1);
    chk("bp stall push_out_n", pon_s, 1);
    chk("bp stall arrive_id", aid_s, 8'h10);
    chk("bp stall z", z_s, 16);
    chk("bp stall census", cen_s, 3);
    chk("nopm ovf", ovf_w, 0);
    chk("nopm arrive_id c4", aid_w, 8'h11);
    tick(); accept_n = 1'b0;
    @(negedge clk);
    chk("bp ovf one cycle", ovf_s, 0);
    chk("bp exit0 id", aid_s, 8'h10);
    chk("bp exit0 push", pon_s, 0);
    chk("nopm arrive_id c5", aid_w, 8'h12);
    tick();
    @(negedge clk);
    chk("bp exit1 id", aid_s, 8'h11);
    chk("bp exit1 push", pon_s, 0);
    chk("nopm arrive_id c6", aid_w, 8'h13);
    tick();
    @(negedge clk);
    chk("bp exit2 id", aid_s, 8'h12);
    chk("bp exit2 push", pon_s, 0);
    tick();
    @(negedge clk);
    chk("bp no dropped id", arr_s, 0);
    chk("bp census empty", cen_s, 0);

    // Bubble collapse: A, gap, B under stall end adjacent.
    tick(); accept_n = 1'b1;
    drive(1'b1, 8'h21, 33); tick();
    launch = 1'b0; tick();
    drive(1'b1, 8'h22, 34); tick();
    launch = 1'b0;
    @(negedge clk);
    chk("collapse census d3", cen_s, 2);
    chk("collapse head id", aid_s, 8'h21);
    tick(); accept_n = 1'b0;
    @(negedge clk);
    chk("collapse census d4", cen_s, 2);
    chk("collapse A push", pon_s, 0);
    chk("collapse A id", aid_s, 8'h21);
    tick();
    @(negedge clk);
    chk("collapse B adjacent arrive", arr_s, 1);
    chk("collapse B adjacent id", aid_s, 8'h22);
    chk("collapse B z", z_s, 34);
    tick();
    @(negedge clk);
    chk("collapse empty", arr_s, 0);

    // Flush with launch asserted, right after a dropped launch.
    tick(); accept_n = 1'b1;
    drive(1'b1, 8'h31, 49); tick();
    drive(1'b1, 8'h32, 50); tick();
    drive(1'b1, 8'h33, 51); tick();
    drive(1'b1, 8'h34, 52);
    @(negedge clk);
    chk("flush pre full", full_s, 1);
    tick(); flush = 1'b1; drive(1'b1, 8'h35, 53);
    @(negedge clk);
    chk("flush prior ovf pulses", ovf_s, 1);
    tick(); flush = 1'b0; launch = 1'b0;
    @(negedge clk);
    chk("flush arrive", arr_s, 0);
    chk("flush census", cen_s, 0);
    chk("flush no ovf", ovf_s, 0);
    chk("flush pipe_full", full_s, 0);
    chk("nopm flush census", cen_w, 0);
    chk("nopm flush arrive", arr_w, 0);
    tick();
    @(negedge clk);
    chk("flush launch dropped", cen_s, 0);
    chk("nopm flush launch dropped", cen_w, 0);

    // Reset in the middle of operation with launch asserted.
    tick(); accept_n = 1'b1;
    drive(1'b1, 8'h41, 9); tick();
    launch = 1'b0; tick(); tick();
    @(negedge clk);
    chk("mid arrive", arr_s, 1);
    chk("mid z", z_s, 9);
    tick(); rst = 1'b1; drive(1'b1, 8'h42, 10);
    tick(); rst = 1'b0; launch = 1'b0;
    @(negedge clk);
    chk_rst("sat mid", z_s, st_s, arr_s, aid_s, pon_s, full_s, ovf_s, cen_s);
    chk_rst("wrap mid", z_w, st_w, arr_w, aid_w, pon_w, full_w, ovf_w, cen_w);
    tick();
    @(negedge clk);
    chk("rst launch dropped", cen_s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lp_piped_sum_n.md
Name: lp_piped_sum_n

Overview:
- Parametrised low-power pipelined N-operand signed integer adder with launch/arrive ID tracking and downstream back-pressure.
- Successor to the fixed 3-operand pipelined sum: operand count, width and depth are generalised.
- New relative to that block: saturating/wrapping result mode, flush, and bubble-collapsing stall.
- Sits between an operand producer (launch handshake) and a consumer (accept_n handshake) in datapath accelerators.

Parameters:
WIDTH, 16, bits per operand and result (two's complement), 4..64
NUM_IN, 4, operand count, 2..16
STAGES, 3, pipeline register stages (latency), 1..8
ID_WIDTH, 8, launch/arrive tag width
SAT_MODE, 1, 1 = saturate result to WIDTH; 0 = wrap modulo 2^WIDTH
NO_PM, 0, 1 = no pipe management: accept_n ignored, pipe never stalls

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
ops  in  NUM_IN*WIDTH  packed operands, operand i at [i*WIDTH +: WIDTH]
launch  in  1  request to issue ops/launch_id this cycle
launch_id  in  ID_WIDTH  tag carried with the operation
flush  in  1  synchronous clear of all in-flight operations
accept_n  in  1  active-low downstream ready
z  out  WIDTH  result of output stage
status  out  2  [0] overflow (saturated or wrapped), [1] z == 0
arrive  out  1  output stage holds valid result
arrive_id  out  ID_WIDTH  tag of output stage
push_out_n  out  1  active-low: result transferred this cycle
pipe_full  out  1  launch cannot be accepted this cycle
pipe_ovf  out  1  one-cycle pulse: a launch was dropped last cycle
pipe_census  out  clog2(STAGES+1)  number of valid stages

Behaviour:
- Arithmetic:
  - Full-precision sum of NUM_IN sign-extended operands, internal width WIDTH+clog2(NUM_IN).
  - SAT_MODE=1: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. SAT_MODE=0: keep low WIDTH bits.
  - status[0]=1 when the full sum is outside the WIDTH range, in both modes.
  - status[1] reflects the final z.
  - Adder-tree partitioning across stages is free; the result must be bit-exact with the full-precision sum at the output stage.
- Stages 1..STAGES, each with a valid bit v[k] plus data/id/status. Stage STAGES drives z, status, arrive_id; arrive = v[STAGES].
- Ready chain (NO_PM=0):
  - ready[STAGES] = ~v[STAGES] | ~accept_n
  - ready[k] = ~v[k] | ready[k+1]
  - Stage k loads from k-1 (stage 1 from inputs) when ready[k].
  - A stage that loads with the upstream stage invalid becomes invalid, so bubbles collapse.
- Launch is accepted iff launch & ready[1]. pipe_full = ~ready[1] (combinational).
- push_out_n = ~(arrive & ~accept_n). Output data holds stable while arrive & accept_n.
- Launch with pipe_full=1: operation dropped, pipeline unchanged, pipe_ovf=1 the next cycle only.
- NO_PM=1:
  - All ready[k]=1; pipeline shifts every cycle.
  - pipe_full=0, pipe_ovf=0.
  - push_out_n = ~arrive; accept_n ignored.
- Latency: STAGES cycles from accepted launch to arrive when unstalled. Throughput is 1 per cycle.
- pipe_census = popcount(v), registered-state derived. It updates in the same cycle as v.
- Flush: all v cleared at the next edge; data/id contents don't-care. A launch in the flush cycle is dropped with no pipe_ovf. pipe_ovf from the previous cycle still pulses.
- Reset (rst=1 at an edge), mid-operation included, wins over flush and launch. After reset:
  - all v=0; z=0, status=0, arrive_id=0, arrive=0
  - push_out_n=1, pipe_full=0, pipe_ovf=0, pipe_census=0
- Reset and flush zero data registers on reset only.

Test Plan:
- Reset: hold rst 2 cycles with launch=1 -> after release: arrive=0, push_out_n=1, pipe_census=0, z=0, pipe_ovf=0.
- Latency (WIDTH=8, NUM_IN=4, STAGES=3, accept_n=0): launch ops {1,2,3,4}, id 0x5A at cycle 0 -> arrive=1, z=10, arrive_id=0x5A, push_out_n=0 at cycle 3. Back-to-back ids 0..9 then exit in order, one per cycle.
- Saturation (SAT_MODE=1, WIDTH=8): ops {100,100,100,0} -> z=127, status=01. Ops {-100,-100,-100,0} -> z=-128 (0x80), status[0]=1. Ops {5,-5,0,0} -> z=0, status=10.
- Wrap (SAT_MODE=0): ops {100,100,100,0} -> z=44, status[0]=1.
- Back-pressure (STAGES=3): accept_n=1, launch every cycle.
  - After 3 accepted launches: pipe_full=1, pipe_census=3.
  - 4th launch dropped -> pipe_ovf=1 one cycle later.
  - Release accept_n -> exactly the 3 ids exit in order; the dropped id never appears.
- Bubble collapse / flush:
  - Launch A, idle 1 cycle, launch B, accept_n=1 -> A and B end adjacent in stages 3,2; pipe_census=2.
  - Assert flush with launch=1 -> next cycle arrive=0, pipe_census=0, pipe_ovf=0.
  - Repeat with NO_PM=1: accept_n=1 is ignored, results still emerge after 3 cycles.
